// File: rtl/line_window_buffer.sv
// Multi-line raster buffer: keeps the previous NUM_LINES-1 lines and emits a
// vertically aligned column of NUM_LINES pixels per accepted input pixel.
module line_window_buffer #(
    parameter int IMG_WIDTH_DATA = 24,
    parameter int IMG_WIDTH_LINE = 800,
    parameter int NUM_LINES      = 3,
    parameter int COL_W          = 11
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                i_vs,
    input  logic                                i_de,
    input  logic [IMG_WIDTH_DATA-1:0]           din,
    output logic                                o_de,
    output logic [NUM_LINES*IMG_WIDTH_DATA-1:0] o_taps,
    output logic [COL_W-1:0]                    o_col,
    output logic                                o_eol
);

    localparam int ADDR_W = (IMG_WIDTH_LINE > 1) ? $clog2(IMG_WIDTH_LINE) : 1;
    localparam int ROW_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int MEM_N  = NUM_LINES - 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH_LINE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_LINES - 1);

    logic [COL_W-1:0]                    col_q;
    logic [ROW_W-1:0]                    row_q;
    logic [COL_W-1:0]                    col_p0;
    logic [ROW_W-1:0]                    row_p0;
    logic [COL_W-1:0]                    col_nxt;
    logic [ROW_W-1:0]                    row_nxt;
    logic                                primed_p0;
    logic [ADDR_W-1:0]                   addr_p0;

    logic                                vld_p1;
    logic [NUM_LINES*IMG_WIDTH_DATA-1:0] taps_p1;
    logic [COL_W-1:0]                    col_p1;
    logic                                eol_p1;

    logic [IMG_WIDTH_DATA-1:0] line_mem [MEM_N][IMG_WIDTH_LINE];

    // ---- stage p0: frame position of the incoming pixel ----
    // A frame-start pulse takes effect before the coincident pixel is placed.
    always_comb begin
        col_p0    = i_vs ? '0 : col_q;
        row_p0    = i_vs ? '0 : row_q;
        primed_p0 = (row_p0 == ROW_LAST);
        addr_p0   = col_p0[ADDR_W-1:0];
        col_nxt   = col_p0;
        row_nxt   = row_p0;
        if (i_de) begin
            if (col_p0 == COL_LAST) begin
                col_nxt = '0;
                if (!primed_p0) begin
                    row_nxt = row_p0 + ROW_W'(1);
                end
            end else begin
                col_nxt = col_p0 + COL_W'(1);
            end
        end
    end

    // Cascaded line delays; the old word shifts one line up as din enters line 1.
    always_ff @(posedge clk) begin
        if (i_de) begin
            line_mem[0][addr_p0] <= din;
            for (int k = 1; k < MEM_N; k++) begin
                line_mem[k][addr_p0] <= line_mem[k-1][addr_p0];
            end
        end
    end

    // ---- stage p1: registered window (memory read happens before the write) ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            vld_p1  <= 1'b0;
            taps_p1 <= '0;
            col_p1  <= '0;
            eol_p1  <= 1'b0;
        end else begin
            col_q  <= col_nxt;
            row_q  <= row_nxt;
            vld_p1 <= i_de && primed_p0;
            if (i_de) begin
                taps_p1[0 +: IMG_WIDTH_DATA] <= din;
                for (int k = 1; k < NUM_LINES; k++) begin
                    taps_p1[k*IMG_WIDTH_DATA +: IMG_WIDTH_DATA] <= line_mem[k-1][addr_p0];
                end
                col_p1 <= col_p0;
                eol_p1 <= (col_p0 == COL_LAST);
            end
        end
    end

    assign o_de   = vld_p1;
    assign o_taps = taps_p1;
    assign o_col  = col_p1;
    assign o_eol  = eol_p1;

endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench for line_window_buffer: a frame-indexed pixel model predicts
// each window; monitors pop and compare whenever a DUT presents o_de.
module tb_line_window_buffer;

    localparam int WA = 8, LA = 4,   NA = 3, CA = 3;
    localparam int WB = 8, LB = 800, NB = 2, CB = 11;

    typedef struct {
        logic [63:0] taps;
        int          col;
        bit          eol;
    } win_t;

    logic clk = 1'b0;
    logic reset;

    logic               vs_a, de_a;
    logic [WA-1:0]      din_a;
    logic               o_de_a, o_eol_a;
    logic [NA*WA-1:0]   o_taps_a;
    logic [CA-1:0]      o_col_a;

    logic               vs_b, de_b;
    logic [WB-1:0]      din_b;
    logic               o_de_b, o_eol_b;
    logic [NB*WB-1:0]   o_taps_b;
    logic [CB-1:0]      o_col_b;

    win_t qa[$];
    win_t qb[$];
    int   fa[$];
    int   fb[$];
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    line_window_buffer #(.IMG_WIDTH_DATA(WA), .IMG_WIDTH_LINE(LA), .NUM_LINES(NA), .COL_W(CA)) dut_a (
        .clk(clk), .reset(reset), .i_vs(vs_a), .i_de(de_a), .din(din_a),
        .o_de(o_de_a), .o_taps(o_taps_a), .o_col(o_col_a), .o_eol(o_eol_a)
    );

    line_window_buffer #(.IMG_WIDTH_DATA(WB), .IMG_WIDTH_LINE(LB), .NUM_LINES(NB), .COL_W(CB)) dut_b (
        .clk(clk), .reset(reset), .i_vs(vs_b), .i_de(de_b), .din(din_b),
        .o_de(o_de_b), .o_taps(o_taps_b), .o_col(o_col_b), .o_eol(o_eol_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: pixel n of the frame sits at row n/LINE, col n%LINE; tap k is pixel n-k*LINE.
    task automatic step_a(input bit vs, input bit de, input int d);
        int   n;
        win_t w;
        @(negedge clk);
        vs_a  = vs;
        de_a  = de;
        din_a = WA'(d);
        if (vs) fa.delete();
        if (de) begin
            n = fa.size();
            fa.push_back(d & 'hff);
            if (n / LA >= NA - 1) begin
                w.taps = '0;
                for (int k = 0; k < NA; k++) w.taps[k*WA +: WA] = WA'(fa[n - k*LA]);
                w.col = n % LA;
                w.eol = (w.col == LA - 1);
                qa.push_back(w);
            end
        end
    endtask

    task automatic step_b(input bit vs, input bit de, input int d);
        int   n;
        win_t w;
        @(negedge clk);
        vs_b  = vs;
        de_b  = de;
        din_b = WB'(d);
        if (vs) fb.delete();
        if (de) begin
            n = fb.size();
            fb.push_back(d & 'hff);
            if (n / LB >= NB - 1) begin
                w.taps = '0;
                for (int k = 0; k < NB; k++) w.taps[k*WB +: WB] = WB'(fb[n - k*LB]);
                w.col = n % LB;
                w.eol = (w.col == LB - 1);
                qb.push_back(w);
            end
        end
    endtask

    // Monitor A: pop on o_de; with no accepted pixel the outputs must hold.
    initial begin
        logic [NA*WA-1:0] p_taps;
        logic [CA-1:0]    p_col;
        logic             p_eol;
        bit               have_prev = 0;
        win_t             w;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                have_prev = 0;
            end else begin
                if (o_de_a) begin
                    if (qa.size() == 0) begin
                        chk("a_unexpected_de", 64'(o_de_a), 64'(0));
                    end else begin
                        w = qa.pop_front();
                        chk("a_taps", 64'(o_taps_a), w.taps);
                        chk("a_col", 64'(o_col_a), 64'(w.col));
                        chk("a_eol", 64'(o_eol_a), 64'(w.eol));
                    end
                end else if (!de_a && have_prev) begin
                    chk("a_hold_taps", 64'(o_taps_a), 64'(p_taps));
                    chk("a_hold_col", 64'(o_col_a), 64'(p_col));
                    chk("a_hold_eol", 64'(o_eol_a), 64'(p_eol));
                end
                p_taps    = o_taps_a;
                p_col     = o_col_a;
                p_eol     = o_eol_a;
                have_prev = 1;
            end
        end
    end

    initial begin
        logic [NB*WB-1:0] p_taps;
        logic [CB-1:0]    p_col;
        logic             p_eol;
        bit               have_prev = 0;
        win_t             w;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                have_prev = 0;
            end else begin
                if (o_de_b) begin
                    if (qb.size() == 0) begin
                        chk("b_unexpected_de", 64'(o_de_b), 64'(0));
                    end else begin
                        w = qb.pop_front();
                        chk("b_taps", 64'(o_taps_b), w.taps);
                        chk("b_col", 64'(o_col_b), 64'(w.col));
                        chk("b_eol", 64'(o_eol_b), 64'(w.eol));
                    end
                end else if (!de_b && have_prev) begin
                    chk("b_hold_taps", 64'(o_taps_b), 64'(p_taps));
                    chk("b_hold_col", 64'(o_col_b), 64'(p_col));
                    chk("b_hold_eol", 64'(o_eol_b), 64'(p_eol));
                end
                p_taps    = o_taps_b;
                p_col     = o_col_b;
                p_eol     = o_eol_b;
                have_prev = 1;
            end
        end
    end

    initial begin
        reset = 1'b1;
        vs_a = 0; de_a = 0; din_a = '0;
        vs_b = 0; de_b = 0; din_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_a_de", 64'(o_de_a), 64'(0));
        chk("rst_a_taps", 64'(o_taps_a), 64'(0));
        chk("rst_a_col", 64'(o_col_a), 64'(0));
        chk("rst_a_eol", 64'(o_eol_a), 64'(0));
        chk("rst_b_de", 64'(o_de_b), 64'(0));
        chk("rst_b_taps", 64'(o_taps_b), 64'(0));
        reset = 1'b0;

        // Continuous frame 1..12
        step_a(1, 0, 0);
        for (int p = 1; p <= 12; p++) step_a(0, 1, p);
        repeat (3) step_a(0, 0, 0);

        // Same stream with 3-cycle gaps after every 2nd pixel; din wiggles during gaps
        step_a(1, 0, 0);
        for (int p = 1; p <= 12; p++) begin
            step_a(0, 1, p);
            if (p % 2 == 0) repeat (3) step_a(0, 0, int'($urandom_range(0, 255)));
        end
        repeat (2) step_a(0, 0, 0);

        // Frame restart after a partial first line set
        step_a(1, 0, 0);
        for (int p = 1; p <= 6; p++) step_a(0, 1, p);
        step_a(1, 0, 0);
        for (int p = 20; p <= 31; p++) step_a(0, 1, p);
        repeat (2) step_a(0, 0, 0);

        // Frame start coincident with the first pixel
        step_a(1, 1, 50);
        for (int p = 51; p <= 61; p++) step_a(0, 1, p);
        repeat (2) step_a(0, 0, 0);

        // Reset while a window is being presented
        step_a(1, 0, 0);
        for (int p = 1; p <= 10; p++) step_a(0, 1, 100 + p);
        @(negedge clk);
        vs_a = 0;
        de_a = 0;
        chk("a_de_before_reset", 64'(o_de_a), 64'(1));
        reset = 1'b1;
        #1;
        chk("a_reset_de", 64'(o_de_a), 64'(0));
        chk("a_reset_taps", 64'(o_taps_a), 64'(0));
        chk("a_reset_col", 64'(o_col_a), 64'(0));
        chk("a_reset_eol", 64'(o_eol_a), 64'(0));
        fa.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int p = 70; p <= 81; p++) step_a(0, 1, p);
        repeat (2) step_a(0, 0, 0);

        // Random traffic: gaps, occasional frame starts, random pixel values
        for (int i = 0; i < 500; i++) begin
            step_a($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
        end
        repeat (2) step_a(0, 0, 0);

        // Two-tap, full-width lines: three lines streamed continuously
        step_b(1, 0, 0);
        for (int i = 0; i < 3 * LB; i++) step_b(0, 1, int'($urandom_range(0, 255)));
        repeat (3) step_b(0, 0, 0);

        chk("a_queue_drained", 64'(qa.size()), 64'(0));
        chk("b_queue_drained", 64'(qb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/line_window_buffer.md
# line_window_buffer

Parametrised multi-line buffer for the binary image pipeline. It stores the previous NUM_LINES-1 lines of a raster pixel stream and presents NUM_LINES vertically aligned pixels (same column, consecutive rows) per input pixel. It feeds the erosion/dilation window stage. Unlike the single-line delay, it wraps its column count every line, restarts on each frame, and gates output until the window is primed.

## Interface
- IMG_WIDTH_DATA, 24, bits per pixel
- IMG_WIDTH_LINE, 800, active pixels per line (>= 2)
- NUM_LINES, 3, number of vertical taps (2..8); NUM_LINES-1 line memories
- COL_W, 11, column counter width; must satisfy 2^COL_W >= IMG_WIDTH_LINE
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- i_vs  in  1  single-cycle frame-start pulse
- i_de  in  1  input pixel valid
- din  in  IMG_WIDTH_DATA  input pixel
- o_de  out  1  output window valid
- o_taps  out  NUM_LINES*IMG_WIDTH_DATA  tap k at bits [k*W +: W]; tap 0 = current row, tap k = k rows above
- o_col  out  COL_W  column index of the output window
- o_eol  out  1  output window is the last column of its line

## Operation
- col counter (0..IMG_WIDTH_LINE-1): increments on each i_de; wraps to 0 after IMG_WIDTH_LINE-1, and row then increments.
- row counter: saturates at NUM_LINES-1. The window is primed when row == NUM_LINES-1.
- Each i_de pixel is written into the line store at address col. In the same cycle, all stored lines are read at address col.
- Read-before-write: tap 1 returns the pixel from the previous line, never the one being written.
- Line store behaves as NUM_LINES-1 cascaded line delays: on write, line k receives the old content of line k-1 at that column, and line 1 receives din.
- o_de = registered (i_de && primed). o_taps, o_col and o_eol update only on cycles where i_de=1 and hold otherwise.
- i_vs=1 forces col=0 and row=0 and clears primed. Memory contents are not cleared; stale data is never exposed because o_de stays low until re-primed.
- i_vs coincident with i_de: the reset applies first. The pixel is written as row 0, col 0, col becomes 1, and o_de stays low for it (NUM_LINES >= 2).
- i_de gaps inside a line: counters hold and alignment is preserved.
- A partial line at i_vs is discarded; no flush.
- Pixels beyond the expected frame height are not policed; the buffer keeps streaming.

## Timing
- Latency: exactly 1 cycle from i_de/din to o_de/o_taps, for all taps.
- o_de is a 1-cycle-delayed copy of the gated i_de; no backpressure. Throughput is 1 pixel/clk sustained.
- First o_de of a frame: the cycle after the first pixel of row NUM_LINES-1 is accepted. That is after (NUM_LINES-1)*IMG_WIDTH_LINE pixels.
- o_eol = 1 with o_de exactly when o_col == IMG_WIDTH_LINE-1.
- Reset (async assert, sync deassert externally):
  - o_de=0, o_taps=0, o_col=0, o_eol=0.
  - col=0, row=0, primed=0.
  - Memory contents undefined.
- Reset mid-line: all outputs are 0 immediately. The next accepted pixel is row 0, col 0 even without i_vs.
- Memory read is synchronous (single-port RAM, read-before-write); no combinational path from din to outputs.

## Test plan
- W=8, LINE=4, NUM_LINES=3; reset, i_vs, then feed pixels 1..12 continuously:
  - o_de is first high one cycle after pixel 9.
  - o_taps = {tap2=1, tap1=5, tap0=9}, o_col=0.
  - Last window = {4, 8, 12} with o_eol=1.
- Same stream with i_de deasserted for 3 cycles after every 2nd pixel -> identical window sequence; o_de pulses only the cycle after each accepted row-2 pixel; outputs hold during gaps.
- Frame restart after 6 pixels (i_vs pulse), then pixels 20..31:
  - No o_de before pixel 28.
  - First window {20, 24, 28}; no stale data from the first frame.
- i_vs and i_de together with din=50, then 11 more pixels 51..61 -> 50 occupies row 0 col 0; first window {50, 54, 58}.
- Assert reset while o_de=1 mid-line -> all outputs 0 that cycle. After release, 12 pixels 70..81 give first window {70, 74, 78}.
- NUM_LINES=2, LINE=800, 3 lines streamed -> o_de low for the first 800 pixels, then 1600 windows with tap1 = pixel 800 earlier; col wraps 799->0 with o_eol=1 at 799.
